// File: rtl/data_bus_bridge_pkg.sv
// Shared bus widths, FSM state encoding and bus size codes for the data bus bridge.
package data_bus_bridge_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Transfer size implied by the byte-enable pattern; irregular patterns fall back to a word.
  function automatic logic [1:0] size_from_sel(input logic [3:0] sel);
    logic [1:0] size;
    case (sel)
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

  // Index of the lowest enabled byte lane (0 when no lane is enabled).
  function automatic logic [1:0] lane_from_sel(input logic [3:0] sel);
    logic [1:0] lane;
    casez (sel)
      4'b???1: lane = 2'd0;
      4'b??10: lane = 2'd1;
      4'b?100: lane = 2'd2;
      4'b1000: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/data_bus_bridge_if.sv
// CPU-side memory port and external bus port of the bridge, bundled together.
interface data_bus_bridge_if;
  import data_bus_bridge_pkg::*;

  logic                mem_en;
  logic                mem_wr;
  logic [3:0]          mem_sel;
  logic [ADDR_BUS-1:0] mem_paddr;
  logic [DATA_BUS-1:0] mem_wdata;
  logic [DATA_BUS-1:0] mem_rdata;
  logic                mem_stall;
  logic                mem_err;

  logic                bus_req;
  logic                bus_wr;
  logic [1:0]          bus_size;
  logic [ADDR_BUS-1:0] bus_addr;
  logic [DATA_BUS-1:0] bus_wdata;
  logic                bus_addr_ok;
  logic                bus_data_ok;
  logic [DATA_BUS-1:0] bus_rdata;

  // Bridge view.
  modport slave (
    input  mem_en, mem_wr, mem_sel, mem_paddr, mem_wdata,
    output mem_rdata, mem_stall, mem_err,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // Environment view: CPU plus bus responder.
  modport master (
    output mem_en, mem_wr, mem_sel, mem_paddr, mem_wdata,
    input  mem_rdata, mem_stall, mem_err,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// CPU memory request to external bus bridge: IDLE/ADDR/DATA/DONE FSM with timeout abort.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_bridge_if.slave  dbb
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  bridge_state_t       state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                latch_req;
  logic                complete;
  logic                timeout_hit;
  logic                bus_req_c;
  logic                stall_c;

  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_BUS-1:0] addr_q;
  logic [DATA_BUS-1:0] wdata_q;
  logic [DATA_BUS-1:0] rdata_q;
  logic                err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake decode; completion wins over timeout in the same cycle.
  always_comb begin
    state_nxt   = state;
    latch_req   = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    bus_req_c   = 1'b0;
    stall_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_c = dbb.mem_en;
        if (dbb.mem_en) begin
          latch_req = 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        bus_req_c = 1'b1;
        stall_c   = 1'b1;
        if (dbb.bus_addr_ok && dbb.bus_data_ok) begin
          complete  = 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_DONE;
        end else if (dbb.bus_addr_ok) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        stall_c = 1'b1;
        if (dbb.bus_data_ok) begin
          complete  = 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (latch_req) begin
        cnt     <= '0;
        wr_q    <= dbb.mem_wr;
        size_q  <= size_from_sel(dbb.mem_sel);
        addr_q  <= {dbb.mem_paddr[ADDR_BUS-1:2], lane_from_sel(dbb.mem_sel)};
        wdata_q <= dbb.mem_wdata;
      end else if (state == ST_ADDR || state == ST_DATA) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit)            rdata_q <= '0;
      else if (complete && !wr_q) rdata_q <= dbb.bus_rdata;
      // Error flag is only ever high for the DONE cycle that follows a timeout.
      err_q <= timeout_hit;
    end
  end

  assign dbb.mem_stall = stall_c;
  assign dbb.bus_req   = bus_req_c;
  assign dbb.mem_rdata = rdata_q;
  assign dbb.mem_err   = err_q;
  assign dbb.bus_wr    = wr_q;
  assign dbb.bus_size  = size_q;
  assign dbb.bus_addr  = addr_q;
  assign dbb.bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed plus randomized checks of data_bus_bridge against a transaction-level model.
module tb_data_bus_bridge;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_bus_bridge_if dbb();

  data_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .dbb (dbb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_size(input logic [3:0] sel);
    if (sel == 4'hF)                    return 2'd2;
    if (sel == 4'h3 || sel == 4'hC)     return 2'd1;
    if ($countones(sel) == 1)           return 2'd0;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] paddr, input logic [3:0] sel);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) if (sel[i]) lane = 2'(i);
    return {paddr[31:2], lane};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, ".stall"},  {31'd0, dbb.mem_stall}, 32'd0);
    chk({tag, ".req"},    {31'd0, dbb.bus_req},   32'd0);
    chk({tag, ".err"},    {31'd0, dbb.mem_err},   32'd0);
    chk({tag, ".rdata"},  dbb.mem_rdata,          32'd0);
    chk({tag, ".wr"},     {31'd0, dbb.bus_wr},    32'd0);
    chk({tag, ".size"},   {30'd0, dbb.bus_size},  32'd0);
    chk({tag, ".addr"},   dbb.bus_addr,           32'd0);
    chk({tag, ".wdata"},  dbb.bus_wdata,          32'd0);
  endtask

  // Caller is in an IDLE cycle just after a rising edge. addr_ok comes in
  // request cycle a; data_ok comes with it (same) or b cycles into the data phase.
  task automatic run_txn(input logic wr, input logic [3:0] sel, input logic [31:0] paddr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int a, input bit same, input int b, input bit hold,
                         input string tag);
    int done_idx, end_idx;
    bit tmo;
    done_idx = same ? a : a + 1 + b;
    tmo      = (done_idx >= int'(TO));
    end_idx  = tmo ? int'(TO) - 1 : done_idx;

    dbb.mem_en = 1'b1; dbb.mem_wr = wr; dbb.mem_sel = sel;
    dbb.mem_paddr = paddr; dbb.mem_wdata = wdata;
    dbb.bus_addr_ok = 1'b0; dbb.bus_data_ok = 1'b0; dbb.bus_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".idle_stall"}, {31'd0, dbb.mem_stall}, 32'd1);
    chk({tag, ".idle_req"},   {31'd0, dbb.bus_req},   32'd0);

    for (int k = 0; k <= end_idx; k++) begin
      @(posedge clk); #1;
      dbb.bus_addr_ok = (k == a);
      dbb.bus_data_ok = (k == done_idx);
      dbb.bus_rdata   = (k == done_idx) ? rdata : $urandom;
      @(negedge clk);
      chk({tag, ".stall"}, {31'd0, dbb.mem_stall}, 32'd1);
      chk({tag, ".req"},   {31'd0, dbb.bus_req},   {31'd0, k <= a});
      if (k <= a) begin
        chk({tag, ".addr"},  dbb.bus_addr,          ref_addr(paddr, sel));
        chk({tag, ".size"},  {30'd0, dbb.bus_size}, {30'd0, ref_size(sel)});
        chk({tag, ".wr"},    {31'd0, dbb.bus_wr},   {31'd0, wr});
        chk({tag, ".wdata"}, dbb.bus_wdata,         wdata);
      end
    end

    @(posedge clk); #1;
    dbb.bus_addr_ok = 1'b0; dbb.bus_data_ok = 1'b0; dbb.bus_rdata = $urandom;
    if (tmo)      exp_rdata = '0;
    else if (!wr) exp_rdata = rdata;
    @(negedge clk);
    chk({tag, ".done_stall"}, {31'd0, dbb.mem_stall}, 32'd0);
    chk({tag, ".done_req"},   {31'd0, dbb.bus_req},   32'd0);
    chk({tag, ".done_err"},   {31'd0, dbb.mem_err},   {31'd0, tmo});
    chk({tag, ".done_rdata"}, dbb.mem_rdata,          exp_rdata);

    @(posedge clk); #1;
    dbb.mem_en = hold;
  endtask

  initial begin
    dbb.mem_en = 1'b0; dbb.mem_wr = 1'b0; dbb.mem_sel = '0;
    dbb.mem_paddr = '0; dbb.mem_wdata = '0;
    dbb.bus_addr_ok = 1'b0; dbb.bus_data_ok = 1'b0; dbb.bus_rdata = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait word read: IDLE, ADDR, DONE.
    run_txn(1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 0, 1'b0, "word_read");

    // Byte write to lane 2 with delayed handshakes.
    run_txn(1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000, 32'h5555_AAAA, 2, 1'b0, 2, 1'b0, "byte_write");

    // No response: abort after TO request cycles, then a clean request.
    run_txn(1'b0, 4'hF, 32'h0000_4000, 32'h0, 32'h0, 99, 1'b0, 0, 1'b0, "timeout");
    run_txn(1'b0, 4'b0011, 32'h0000_4004, 32'h0, 32'h1111_2222, 1, 1'b1, 0, 1'b0, "after_tmo");

    // Responses while idle must do nothing.
    dbb.mem_en = 1'b0; dbb.bus_addr_ok = 1'b1; dbb.bus_data_ok = 1'b1; dbb.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("idle_noise.stall", {31'd0, dbb.mem_stall}, 32'd0);
    chk("idle_noise.req",   {31'd0, dbb.bus_req},   32'd0);
    @(posedge clk); #1;
    dbb.bus_addr_ok = 1'b0; dbb.bus_data_ok = 1'b0;
    @(negedge clk);
    chk("idle_noise.rdata", dbb.mem_rdata,          exp_rdata);
    chk("idle_noise.err",   {31'd0, dbb.mem_err},   32'd0);
    chk("idle_noise.stall2",{31'd0, dbb.mem_stall}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back reads with mem_en held across DONE.
    run_txn(1'b0, 4'hF, 32'h0000_5000, 32'h0, 32'h0123_4567, 0, 1'b1, 0, 1'b1, "b2b_first");
    run_txn(1'b0, 4'hF, 32'h0000_5004, 32'h0, 32'h89AB_CDEF, 0, 1'b1, 0, 1'b0, "b2b_second");

    // Randomized transactions, including occasional timeouts.
    for (int i = 0; i < 24; i++) begin
      logic       r_wr, r_same, r_hold;
      logic [3:0] r_sel;
      int         r_a, r_b;
      r_wr   = 1'($urandom_range(0, 1));
      r_sel  = 4'($urandom_range(0, 15));
      r_a    = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 5));
      r_same = 1'($urandom_range(0, 1));
      r_b    = int'($urandom_range(0, 4));
      r_hold = 1'($urandom_range(0, 1));
      run_txn(r_wr, r_sel, $urandom, $urandom, $urandom, r_a, r_same, r_b, r_hold, "rand");
    end
    dbb.mem_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in the data phase, then a stray data_ok.
    dbb.mem_en = 1'b1; dbb.mem_wr = 1'b0; dbb.mem_sel = 4'hF;
    dbb.mem_paddr = 32'h0000_3000; dbb.mem_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    dbb.bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    dbb.bus_addr_ok = 1'b0; dbb.mem_en = 1'b0;
    @(negedge clk);
    chk("rst_data.stall", {31'd0, dbb.mem_stall}, 32'd1);
    chk("rst_data.req",   {31'd0, dbb.bus_req},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dbb.bus_data_ok = 1'b1; dbb.bus_rdata = 32'h1234_5678;
    exp_rdata = '0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    dbb.bus_data_ok = 1'b0;
    @(negedge clk);
    check_all_zero("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a transaction may spend in ADDR plus DATA before it is aborted.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 mem_en  input  1  CPU memory request, held stable while mem_stall=1.
REQ-005 mem_wr  input  1  1=write, 0=read.
REQ-006 mem_sel  input  4  byte enables, little-endian lanes.
REQ-007 mem_paddr  input  32  physical address, already translated upstream.
REQ-008 mem_wdata  input  32  write data, lane-aligned.
REQ-009 mem_rdata  output  32  read data, valid in the DONE cycle.
REQ-010 mem_stall  output  1  pipeline hold.
REQ-011 mem_err  output  1  timeout flag, valid in the DONE cycle.
REQ-012 bus_req  output  1  bus request.
REQ-013 bus_wr  output  1  bus write.
REQ-014 bus_size  output  2  0=byte, 1=half, 2=word.
REQ-015 bus_addr  output  32  bus address.
REQ-016 bus_wdata  output  32  bus write data.
REQ-017 bus_addr_ok  input  1  address accepted.
REQ-018 bus_data_ok  input  1  data phase complete.
REQ-019 bus_rdata  input  32  read data, valid with bus_data_ok.

Function
REQ-020 The FSM SHALL have states IDLE, ADDR, DATA and DONE, one-hot or binary.
- IDLE with mem_en=1: latch wr, sel, paddr and wdata; go to ADDR.
REQ-021 In ADDR, bus_req SHALL be 1 and the bus outputs SHALL show the latched request.
- addr_ok=1 and data_ok=0: go to DATA.
- addr_ok=1 and data_ok=1 in the same cycle: go to DONE.
REQ-022 In DATA, bus_req SHALL be 0; data_ok=1 goes to DONE.
REQ-023 On the data_ok edge, rdata SHALL be captured into mem_rdata for a read; for a write, mem_rdata SHALL keep its old value.
REQ-024 DONE SHALL last exactly 1 cycle, then return to IDLE.
REQ-025 mem_stall SHALL equal (IDLE & mem_en) | ADDR | DATA, combinational; it is 0 in DONE.
REQ-026 A request arriving in the cycle after DONE SHALL be accepted from IDLE with no lost cycle beyond IDLE.
REQ-027 bus_size SHALL be encoded from sel:
- 1111 gives 2.
- 0011 or 1100 gives 1.
- A one-hot pattern gives 0.
- Any other pattern gives 2.
REQ-028 bus_addr SHALL be paddr with bits[1:0] forced to the lowest set lane index.
REQ-029 The timeout counter SHALL clear on the IDLE->ADDR transition and increment each cycle in ADDR or DATA.
- At count==TIMEOUT-1 without completion: go to DONE with mem_err=1 and mem_rdata=0.
REQ-030 mem_err SHALL be 0 in every DONE not caused by a timeout.
REQ-031 addr_ok or data_ok arriving in IDLE or DONE SHALL be ignored.
REQ-032 bus_addr, bus_wr, bus_size and bus_wdata SHALL be registered from the latch and SHALL stay stable through ADDR.
REQ-033 Latency with zero-wait-state responses SHALL be 3 cycles from mem_en rising to DONE (IDLE, ADDR, DONE).

Reset
REQ-034 While rst=0 at a clock edge, the state SHALL go to IDLE and the counter SHALL clear.
- mem_rdata=0, mem_err=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0.
REQ-035 Reset asserted mid-transaction SHALL drop bus_req at that edge, and any later data_ok SHALL be ignored.

Structure
REQ-036 Bus widths SHALL come from the shared bus define header (ADDR_BUS, DATA_BUS).
- State encodings and size codes SHALL be added to that header.
REQ-037 No sub-module: the FSM, timeout counter and size encoder SHALL be one module.

Verification
REQ-038 Word read of 0x0000_1000, sel=1111, addr_ok and data_ok in the same cycle as bus_req:
- Expect bus_size=2 and DONE 3 cycles after mem_en.
- Expect mem_rdata = bus_rdata (0xCAFE_F00D) and mem_err=0.
REQ-039 Byte write, sel=0100, paddr 0x0000_2000:
- Expect bus_addr=0x0000_2002, bus_size=0 and bus_wr=1.
- With addr_ok delayed 2 cycles and data_ok 3 cycles later, mem_stall=1 until DONE.
REQ-040 No responses, TIMEOUT=8:
- Expect DONE after 8 ADDR cycles with mem_err=1 and mem_rdata=0.
- The next request SHALL show mem_err=0.
REQ-041 Reset asserted in DATA, then data_ok pulsed:
- Expect IDLE, all outputs 0 and no DONE.
REQ-042 Back-to-back reads with mem_en held across DONE:
- Expect a second bus_req 2 cycles after the first DONE and distinct captured data.
